// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALUOp encodings, control-bundle layout
// and the opcodes the decoder in front of this stage understands.
package id_ex_stage_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam int CTRL_W         = 8;
    localparam int CTRL_REGDST    = 0;
    localparam int CTRL_ALUSRC    = 1;
    localparam int CTRL_ALUOP_LSB = 2;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_MEMRD     = 4;
    localparam int CTRL_MEMWR     = 5;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_REGWRITE  = 7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic       reg_dst,
        input logic       alu_src,
        input logic [1:0] alu_op,
        input logic       mem_rd,
        input logic       mem_wr,
        input logic       mem_to_reg,
        input logic       reg_write
    );
        logic [CTRL_W-1:0] c;
        c = {CTRL_W{1'b0}};
        c[CTRL_REGDST]                   = reg_dst;
        c[CTRL_ALUSRC]                   = alu_src;
        c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = alu_op;
        c[CTRL_MEMRD]                    = mem_rd;
        c[CTRL_MEMWR]                    = mem_wr;
        c[CTRL_MEMTOREG]                 = mem_to_reg;
        c[CTRL_REGWRITE]                 = reg_write;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-side inputs, EX-side registered copies,
// the load-use stall request and the stall counter.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  RegDst_i;
    logic                  ALUSrc_i;
    logic [1:0]            ALUOp_i;
    logic                  MemRd_i;
    logic                  MemWr_i;
    logic                  MemtoReg_i;
    logic                  RegWrite_i;
    logic [DATA_W-1:0]     pc4_i;
    logic [DATA_W-1:0]     rs_data_i;
    logic [DATA_W-1:0]     rt_data_i;
    logic [DATA_W-1:0]     imm_i;
    logic [REG_ADDR_W-1:0] rs_i;
    logic [REG_ADDR_W-1:0] rt_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic                  flush_i;

    logic                  stall_o;
    logic                  ex_RegDst_o;
    logic                  ex_ALUSrc_o;
    logic [1:0]            ex_ALUOp_o;
    logic                  ex_MemRd_o;
    logic                  ex_MemWr_o;
    logic                  ex_MemtoReg_o;
    logic                  ex_RegWrite_o;
    logic [DATA_W-1:0]     ex_pc4_o;
    logic [DATA_W-1:0]     ex_rs_data_o;
    logic [DATA_W-1:0]     ex_rt_data_o;
    logic [DATA_W-1:0]     ex_imm_o;
    logic [REG_ADDR_W-1:0] ex_rs_o;
    logic [REG_ADDR_W-1:0] ex_rt_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;
    logic                  ex_valid_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output RegDst_i, ALUSrc_i, ALUOp_i, MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i,
               pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, flush_i,
        input  stall_o, ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, ex_MemRd_o, ex_MemWr_o,
               ex_MemtoReg_o, ex_RegWrite_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o,
               ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o, stall_cnt_o
    );

    modport slave (
        input  RegDst_i, ALUSrc_i, ALUOp_i, MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i,
               pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, flush_i,
        output stall_o, ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, ex_MemRd_o, ex_MemWr_o,
               ex_MemtoReg_o, ex_RegWrite_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o,
               ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: the load in EX targets a register the ID instruction reads.
// rt is always compared, even when the ID instruction does not use it.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hz
);
    // Register $zero never carries a dependency.
    always_comb begin
        hz = ex_mem_rd & (ex_rt != {REG_ADDR_W{1'b0}}) & ((ex_rt == rs) | (ex_rt == rt));
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump flush
// and a saturating count of stall cycles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);
    logic [CTRL_W-1:0]     ctrl_in_s;
    logic [CTRL_W-1:0]     ctrl_r;
    logic [DATA_W-1:0]     pc4_r;
    logic [DATA_W-1:0]     rs_data_r;
    logic [DATA_W-1:0]     rt_data_r;
    logic [DATA_W-1:0]     imm_r;
    logic [REG_ADDR_W-1:0] rs_r;
    logic [REG_ADDR_W-1:0] rt_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic                  valid_r;
    logic [CNT_W-1:0]      stall_cnt_r;
    logic                  hz_s;
    logic                  stall_s;
    logic                  bubble_s;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .ex_mem_rd (ctrl_r[CTRL_MEMRD]),
        .ex_rt     (rt_r),
        .rs        (bus.rs_i),
        .rt        (bus.rt_i),
        .hz        (hz_s)
    );

    // A flushed instruction is discarded anyway, so it never needs a stall.
    always_comb begin
        ctrl_in_s = pack_ctrl(bus.RegDst_i, bus.ALUSrc_i, bus.ALUOp_i, bus.MemRd_i,
                              bus.MemWr_i, bus.MemtoReg_i, bus.RegWrite_i);
        stall_s   = hz_s & ~bus.flush_i;
        bubble_s  = hz_s | bus.flush_i;
    end

    // Register bank: reset, then bubble (flush or load-use), else load the ID slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_r      <= {CTRL_W{1'b0}};
            pc4_r       <= {DATA_W{1'b0}};
            rs_data_r   <= {DATA_W{1'b0}};
            rt_data_r   <= {DATA_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            rs_r        <= {REG_ADDR_W{1'b0}};
            rt_r        <= {REG_ADDR_W{1'b0}};
            rd_r        <= {REG_ADDR_W{1'b0}};
            valid_r     <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (bubble_s) begin
                ctrl_r    <= {CTRL_W{1'b0}};
                pc4_r     <= {DATA_W{1'b0}};
                rs_data_r <= {DATA_W{1'b0}};
                rt_data_r <= {DATA_W{1'b0}};
                imm_r     <= {DATA_W{1'b0}};
                rs_r      <= {REG_ADDR_W{1'b0}};
                rt_r      <= {REG_ADDR_W{1'b0}};
                rd_r      <= {REG_ADDR_W{1'b0}};
                valid_r   <= 1'b0;
            end else begin
                ctrl_r    <= ctrl_in_s;
                pc4_r     <= bus.pc4_i;
                rs_data_r <= bus.rs_data_i;
                rt_data_r <= bus.rt_data_i;
                imm_r     <= bus.imm_i;
                rs_r      <= bus.rs_i;
                rt_r      <= bus.rt_i;
                rd_r      <= bus.rd_i;
                valid_r   <= 1'b1;
            end
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign bus.stall_o       = stall_s;
    assign bus.ex_RegDst_o   = ctrl_r[CTRL_REGDST];
    assign bus.ex_ALUSrc_o   = ctrl_r[CTRL_ALUSRC];
    assign bus.ex_ALUOp_o    = ctrl_r[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB];
    assign bus.ex_MemRd_o    = ctrl_r[CTRL_MEMRD];
    assign bus.ex_MemWr_o    = ctrl_r[CTRL_MEMWR];
    assign bus.ex_MemtoReg_o = ctrl_r[CTRL_MEMTOREG];
    assign bus.ex_RegWrite_o = ctrl_r[CTRL_REGWRITE];
    assign bus.ex_pc4_o      = pc4_r;
    assign bus.ex_rs_data_o  = rs_data_r;
    assign bus.ex_rt_data_o  = rt_data_r;
    assign bus.ex_imm_o      = imm_r;
    assign bus.ex_rs_o       = rs_r;
    assign bus.ex_rt_o       = rt_r;
    assign bus.ex_rd_o       = rd_r;
    assign bus.ex_valid_o    = valid_r;
    assign bus.stall_cnt_o   = stall_cnt_r;

endmodule
